// File: rtl/hex_scroll_display.sv
// -----------------------------------------------------------------------------
// hex_scroll_display
//
// Scrolls the eight nibbles of a 32-bit word as a marquee across the six
// on-board seven-segment digits. The step period is set in base ticks by
// `speed`. A new word is only adopted at a scroll boundary, so a pass in
// progress is never torn.
//
// Optional build macro: HEX_GAP_EN
//   defined   -> scroll length 10. Positions 8 and 9 are blank, which leaves a
//                two-digit gap between passes.
//   undefined -> scroll length 8, with a continuous wrap.
//
// Parameters:
//   TICK_DIV      clk_clk cycles per base tick
//   SPEED_W       width of the speed input
//
// Ports:
//   clk_clk       in   system clock
//   reset_reset_n in   asynchronous active-low reset
//   hex_word      in   [31:0] word to display, nibble 0 = bits 3:0
//   speed         in   [SPEED_W-1:0] step period in base ticks, 0 = frozen
//   enable        in   1 = run, 0 = hold the tick counter, step counter and position
//   hex0..hex5    out  [6:0] active-low segments, bit0=a .. bit6=g, hex0 rightmost
//   scroll_pos    out  [3:0] current scroll position
//   word_loaded   out  one-cycle pulse when a new word is latched
// -----------------------------------------------------------------------------
module hex_scroll_display #(
    parameter int TICK_DIV = 50000,
    parameter int SPEED_W  = 10
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [31:0]        hex_word,
    input  logic [SPEED_W-1:0] speed,
    input  logic               enable,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3,
    output logic [6:0]         hex4,
    output logic [6:0]         hex5,
    output logic [3:0]         scroll_pos,
    output logic               word_loaded
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0]  TICK_ONE   = TICK_W'(1);
    localparam logic [TICK_W-1:0]  TICK_ZERO  = {TICK_W{1'b0}};
    localparam logic [SPEED_W-1:0] SPEED_ONE  = SPEED_W'(1);
    localparam logic [SPEED_W-1:0] SPEED_ZERO = {SPEED_W{1'b0}};

`ifdef HEX_GAP_EN
    localparam logic [3:0] LAST_POS   = 4'd9;
    localparam logic [4:0] SCROLL_LEN = 5'd10;
`else
    localparam logic [3:0] LAST_POS   = 4'd7;
    localparam logic [4:0] SCROLL_LEN = 5'd8;
`endif

    // Convert a nibble to the active-low segment pattern (bit0 = a).
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Digit `digit` shows nibble (pos + digit) mod SCROLL_LEN. Indices 8 and
    // above fall in the gap and are blank.
    function automatic logic [6:0] digit_seg(input logic [31:0] word,
                                             input logic [3:0]  pos,
                                             input logic [2:0]  digit);
        logic [4:0] idx;
        logic [6:0] seg;
        idx = {1'b0, pos} + {2'b00, digit};
        if (idx >= SCROLL_LEN) begin
            idx = idx - SCROLL_LEN;
        end else begin
            idx = idx;
        end
        if (idx >= 5'd8) begin
            seg = 7'h7F;
        end else begin
            seg = seg_decode(word[{idx[2:0], 2'b00} +: 4]);
        end
        return seg;
    endfunction

    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [SPEED_W-1:0] step_cnt_q, step_cnt_d;
    logic [3:0]         pos_q, pos_d;
    logic [31:0]        word_q, word_d;
    logic               first_q, first_d;
    logic               loaded_q, loaded_d;
    logic [6:0]         hex_q [6];
    logic [6:0]         seg_d [6];

    logic tick_s;
    logic step_s;
    logic wrap_s;
    logic pending_s;
    logic load_s;

    // Base tick counter. The strobe fires in the cycle in which the count wraps.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tick_s     = 1'b0;
        if (enable) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = TICK_ZERO;
                tick_s     = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_ONE;
            end
        end else begin
            tick_cnt_d = tick_cnt_q;
        end
    end

    // Step counter. The >= comparison makes a step fire on the next tick
    // when speed drops below the current count.
    always_comb begin
        step_cnt_d = step_cnt_q;
        step_s     = 1'b0;
        if (speed == SPEED_ZERO) begin
            step_cnt_d = SPEED_ZERO;
        end else if (tick_s) begin
            if (step_cnt_q >= (speed - SPEED_ONE)) begin
                step_cnt_d = SPEED_ZERO;
                step_s     = 1'b1;
            end else begin
                step_cnt_d = step_cnt_q + SPEED_ONE;
            end
        end else begin
            step_cnt_d = step_cnt_q;
        end
    end

    // Scroll position and word adoption. A wrap-triggered load lands in the
    // same cycle as the position returning to 0.
    always_comb begin
        pos_d     = pos_q;
        word_d    = word_q;
        first_d   = first_q;
        wrap_s    = step_s && (pos_q == LAST_POS);
        pending_s = (hex_word != word_q);
        load_s    = pending_s && (first_q || (speed == SPEED_ZERO) || wrap_s);
        if (step_s) begin
            if (wrap_s) begin
                pos_d = 4'd0;
            end else begin
                pos_d = pos_q + 4'd1;
            end
        end else begin
            pos_d = pos_q;
        end
        if (load_s) begin
            word_d  = hex_word;
            first_d = 1'b0;
        end else begin
            word_d  = word_q;
            first_d = first_q;
        end
        loaded_d = load_s;
    end

    // Segment patterns for every digit, taken from the current latched state.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            seg_d[i] = digit_seg(word_q, pos_q, 3'(i));
        end
    end

    // State and output registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tick_cnt_q <= TICK_ZERO;
            step_cnt_q <= SPEED_ZERO;
            pos_q      <= 4'd0;
            word_q     <= 32'h0000_0000;
            first_q    <= 1'b1;
            loaded_q   <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= 7'h7F;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            step_cnt_q <= step_cnt_d;
            pos_q      <= pos_d;
            word_q     <= word_d;
            first_q    <= first_d;
            loaded_q   <= loaded_d;
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= seg_d[i];
            end
        end
    end

    assign hex0        = hex_q[0];
    assign hex1        = hex_q[1];
    assign hex2        = hex_q[2];
    assign hex3        = hex_q[3];
    assign hex4        = hex_q[4];
    assign hex5        = hex_q[5];
    assign scroll_pos  = pos_q;
    assign word_loaded = loaded_q;

endmodule

// File: tb/tb_hex_scroll_display.sv
module tb_hex_scroll_display;

`ifdef HEX_GAP_EN
    localparam int L = 10;
`else
    localparam int L = 8;
`endif

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b1;
    logic [31:0] hex_word = 32'h0;
    logic [9:0]  speed = 10'd0;
    logic        enable = 1'b1;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [3:0]  scroll_pos;
    logic        word_loaded;

    int pass_cnt  = 0;
    int total_cnt = 0;

    hex_scroll_display #(.TICK_DIV(4), .SPEED_W(10)) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .hex_word     (hex_word),
        .speed        (speed),
        .enable       (enable),
        .hex0         (hex0),
        .hex1         (hex1),
        .hex2         (hex2),
        .hex3         (hex3),
        .hex4         (hex4),
        .hex5         (hex5),
        .scroll_pos   (scroll_pos),
        .word_loaded  (word_loaded)
    );

    always #5 clk_clk = ~clk_clk;

    function automatic logic [41:0] disp();
        return {hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    task automatic do_reset(input logic [31:0] w, input logic [9:0] s);
        @(negedge clk_clk);
        reset_reset_n = 1'b0;
        hex_word = w;
        speed = s;
        enable = 1'b1;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
    endtask

    // Waits (bounded) for scroll_pos to change; returns negedges elapsed.
    task automatic wait_step(output int cycles);
        logic [3:0] old;
        old = scroll_pos;
        cycles = 0;
        do begin
            @(negedge clk_clk);
            cycles++;
        end while (scroll_pos == old && cycles < 1000);
    endtask

    task automatic test_reset();
        #2 reset_reset_n = 1'b0;
        #1;
        total_cnt++;
        if (disp() !== {6{7'h7F}}) $display("FAIL reset_hex: got %h expected %h", disp(), {6{7'h7F}});
        else pass_cnt++;
        total_cnt++;
        if ({scroll_pos, word_loaded} !== 5'b0) $display("FAIL reset_pos_loaded: got %b expected %b", {scroll_pos, word_loaded}, 5'b0);
        else pass_cnt++;
    endtask

    task automatic test_frozen_load();
        do_reset(32'h0012_3456, 10'd0);
        @(negedge clk_clk);
        total_cnt++;
        if (word_loaded !== 1'b1) $display("FAIL first_load_pulse: got %b expected 1", word_loaded);
        else pass_cnt++;
        total_cnt++;
        if (disp() !== {6{7'h40}}) $display("FAIL decode_latency: got %h expected %h", disp(), {6{7'h40}});
        else pass_cnt++;
        @(negedge clk_clk);
        total_cnt++;
        if ({word_loaded, disp()} !== {1'b0, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02})
            $display("FAIL first_word_display: got %h expected %h", {word_loaded, disp()}, {1'b0, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        else pass_cnt++;
        hex_word = 32'hABCD_EF01;
        @(negedge clk_clk);
        total_cnt++;
        if (word_loaded !== 1'b1) $display("FAIL speed0_load_pulse: got %b expected 1", word_loaded);
        else pass_cnt++;
        @(negedge clk_clk);
        total_cnt++;
        if (disp() !== {7'h46, 7'h21, 7'h06, 7'h0E, 7'h40, 7'h79})
            $display("FAIL speed0_display: got %h expected %h", disp(), {7'h46, 7'h21, 7'h06, 7'h0E, 7'h40, 7'h79});
        else pass_cnt++;
        repeat (20) @(negedge clk_clk);
        total_cnt++;
        if (scroll_pos !== 4'd0) $display("FAIL frozen_pos: got %0d expected 0", scroll_pos);
        else pass_cnt++;
    endtask

    task automatic test_scroll();
        int cyc;
        do_reset(32'h8765_4321, 10'd3);
        wait_step(cyc);
        total_cnt++;
        if ({cyc, scroll_pos} !== {32'd12, 4'd1}) $display("FAIL first_step: got cyc=%0d pos=%0d expected cyc=12 pos=1", cyc, scroll_pos);
        else pass_cnt++;
        @(negedge clk_clk);
        total_cnt++;
        if ({hex5, hex1, hex0} !== {7'h78, 7'h30, 7'h24}) $display("FAIL pos1_digits: got %h expected %h", {hex5, hex1, hex0}, {7'h78, 7'h30, 7'h24});
        else pass_cnt++;
        for (int k = 2; k <= 8; k++) begin
            wait_step(cyc);
            total_cnt++;
            if ({cyc, scroll_pos} !== {((k == 2) ? 32'd11 : 32'd12), 4'(k % L)})
                $display("FAIL step_%0d: got cyc=%0d pos=%0d expected pos=%0d", k, cyc, scroll_pos, k % L);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap_adoption();
        int cyc;
        int n;
        int loads;
        logic [3:0] prev;
        logic seen;
        while (scroll_pos != 4'd3) wait_step(cyc);
        hex_word = 32'hFFFF_FFFF;
        prev = scroll_pos;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 400) begin
            @(negedge clk_clk);
            n++;
            if (word_loaded) seen = 1'b1;
            else prev = scroll_pos;
        end
        total_cnt++;
        if ({seen, scroll_pos, prev} !== {1'b1, 4'd0, 4'(L - 1)})
            $display("FAIL wrap_load: got seen=%b pos=%0d prev=%0d expected seen=1 pos=0 prev=%0d", seen, scroll_pos, prev, L - 1);
        else pass_cnt++;
        total_cnt++;
        if (n !== (L - 3) * 12) $display("FAIL wrap_load_time: got %0d expected %0d", n, (L - 3) * 12);
        else pass_cnt++;
        @(negedge clk_clk);
        total_cnt++;
        if (disp() !== {6{7'h0E}}) $display("FAIL wrap_display: got %h expected %h", disp(), {6{7'h0E}});
        else pass_cnt++;
        hex_word = 32'h1111_1111;
        loads = 0;
        repeat (5) begin
            @(negedge clk_clk);
            if (word_loaded) loads++;
        end
        hex_word = 32'hFFFF_FFFF;
        repeat (L * 12 + 10) begin
            @(negedge clk_clk);
            if (word_loaded) loads++;
        end
        total_cnt++;
        if (loads !== 0) $display("FAIL revert_no_load: got %0d loads expected 0", loads);
        else pass_cnt++;
    endtask

    task automatic test_speed_drop();
        int cyc;
        do_reset(32'h7654_3210, 10'd10);
        repeat (24) @(negedge clk_clk);
        total_cnt++;
        if (scroll_pos !== 4'd0) $display("FAIL pre_drop_pos: got %0d expected 0", scroll_pos);
        else pass_cnt++;
        speed = 10'd1;
        wait_step(cyc);
        total_cnt++;
        if ({cyc, scroll_pos} !== {32'd4, 4'd1}) $display("FAIL drop_step: got cyc=%0d pos=%0d expected cyc=4 pos=1", cyc, scroll_pos);
        else pass_cnt++;
        wait_step(cyc);
        total_cnt++;
        if ({cyc, scroll_pos} !== {32'd4, 4'd2}) $display("FAIL per_tick_step: got cyc=%0d pos=%0d expected cyc=4 pos=2", cyc, scroll_pos);
        else pass_cnt++;
    endtask

    task automatic test_enable_hold();
        int cyc;
        repeat (3) wait_step(cyc);
        @(negedge clk_clk);
        enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_clk);
            total_cnt++;
            if ({scroll_pos, hex2, hex1, hex0} !== {4'd5, 7'h78, 7'h02, 7'h12})
                $display("FAIL hold_%0d: got %h expected %h", i, {scroll_pos, hex2, hex1, hex0}, {4'd5, 7'h78, 7'h02, 7'h12});
            else pass_cnt++;
        end
        enable = 1'b1;
        wait_step(cyc);
        total_cnt++;
        if ({cyc, scroll_pos} !== {32'd3, 4'd6}) $display("FAIL resume: got cyc=%0d pos=%0d expected cyc=3 pos=6", cyc, scroll_pos);
        else pass_cnt++;
    endtask

    task automatic test_disabled_load();
        enable = 1'b0;
        speed = 10'd0;
        hex_word = 32'hC000_00A5;
        @(negedge clk_clk);
        total_cnt++;
        if (word_loaded !== 1'b1) $display("FAIL disabled_load_pulse: got %b expected 1", word_loaded);
        else pass_cnt++;
        @(negedge clk_clk);
        total_cnt++;
        if ({scroll_pos, hex1, hex0} !== {4'd6, 7'h46, 7'h40}) $display("FAIL disabled_load_display: got %h expected %h", {scroll_pos, hex1, hex0}, {4'd6, 7'h46, 7'h40});
        else pass_cnt++;
        enable = 1'b1;
    endtask

    task automatic test_gap_and_reset();
        int cyc;
        do_reset(32'h7654_3210, 10'd1);
        for (int k = 1; k <= L; k++) begin
            wait_step(cyc);
            total_cnt++;
            if (scroll_pos !== 4'(k % L)) $display("FAIL cycle_pos_%0d: got %0d expected %0d", k, scroll_pos, k % L);
            else pass_cnt++;
`ifdef HEX_GAP_EN
            if (k == 8) begin
                @(negedge clk_clk);
                total_cnt++;
                if ({hex2, hex1, hex0} !== {7'h40, 7'h7F, 7'h7F}) $display("FAIL gap_digits: got %h expected %h", {hex2, hex1, hex0}, {7'h40, 7'h7F, 7'h7F});
                else pass_cnt++;
            end
`else
            if (k == 7) begin
                @(negedge clk_clk);
                total_cnt++;
                if ({hex2, hex1, hex0} !== {7'h79, 7'h40, 7'h78}) $display("FAIL wrap_digits: got %h expected %h", {hex2, hex1, hex0}, {7'h79, 7'h40, 7'h78});
                else pass_cnt++;
            end
`endif
        end
        repeat (7) wait_step(cyc);
        total_cnt++;
        if (scroll_pos !== 4'd7) $display("FAIL pre_reset_pos: got %0d expected 7", scroll_pos);
        else pass_cnt++;
        #2 reset_reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({disp(), scroll_pos, word_loaded} !== {{6{7'h7F}}, 4'd0, 1'b0})
            $display("FAIL midscroll_reset: got %h expected %h", {disp(), scroll_pos, word_loaded}, {{6{7'h7F}}, 4'd0, 1'b0});
        else pass_cnt++;
        hex_word = 32'h0000_0005;
        speed = 10'd0;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        total_cnt++;
        if (word_loaded !== 1'b1) $display("FAIL post_reset_load: got %b expected 1", word_loaded);
        else pass_cnt++;
        @(negedge clk_clk);
        total_cnt++;
        if ({hex1, hex0} !== {7'h40, 7'h12}) $display("FAIL post_reset_display: got %h expected %h", {hex1, hex0}, {7'h40, 7'h12});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_frozen_load();
        test_scroll();
        test_wrap_adoption();
        test_speed_drop();
        test_enable_hold();
        test_disabled_load();
        test_gap_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
